// File: rtl/data_memory_responder_if.sv
// Request/response bus between the main controller and the data memory responder.
interface data_memory_responder_if;
    logic        memoryRead;
    logic        memoryWrite;
    logic [63:0] address;
    logic [63:0] writeData;
    logic [63:0] readData;
    logic        ready;
    logic        busy;
    logic        error;

    modport master (
        output memoryRead, memoryWrite, address, writeData,
        input  readData, ready, busy, error
    );

    modport slave (
        input  memoryRead, memoryWrite, address, writeData,
        output readData, ready, busy, error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Doubleword data memory with a fixed-latency IDLE/WAIT/DONE handshake.
// Optional macro DMEM_MISALIGN_CHECK_EN: flag and suppress accesses with address[2:0] != 0.
module data_memory_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 32
) (
    input  logic clock,
    input  logic resetN,
    data_memory_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              op_wr;
    logic [IDX_W-1:0]  idx;
    logic [63:0]       wdata;
    logic              misal;
    logic [63:0]       rdata;
    logic              err;
    logic [63:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              in_misal;
    logic [IDX_W-1:0]  in_idx;
    logic              commit_go;
    logic              commit_wr;
    logic [IDX_W-1:0]  commit_idx;
    logic [63:0]       commit_data;
    logic              commit_misal;
    logic              unused_addr;

    assign accept      = (state == IDLE) && (bus.memoryRead ^ bus.memoryWrite);
    assign in_idx      = bus.address[3 +: IDX_W];
    assign unused_addr = ^bus.address;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign in_misal = (bus.address[2:0] != 3'b000);
`else
    assign in_misal = 1'b0;
`endif

    // The commit happens on the edge entering DONE; with no wait cycles that
    // edge is also the acceptance edge, so the live request is used directly.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        commit_go    = 1'b0;
        commit_wr    = op_wr;
        commit_idx   = idx;
        commit_data  = wdata;
        commit_misal = misal;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt    = DONE;
                        commit_go    = 1'b1;
                        commit_wr    = bus.memoryWrite;
                        commit_idx   = in_idx;
                        commit_data  = bus.writeData;
                        commit_misal = in_misal;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_CYCLES[3:0];
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    commit_go = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_wr <= 1'b0;
            idx   <= '0;
            wdata <= 64'd0;
            misal <= 1'b0;
            rdata <= 64'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_wr <= bus.memoryWrite;
                idx   <= in_idx;
                wdata <= bus.writeData;
                misal <= in_misal;
            end
            if (commit_go && !commit_wr && !commit_misal)
                rdata <= mem[commit_idx];
            err <= commit_go && commit_misal;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (commit_go && commit_wr && !commit_misal)
            mem[commit_idx] <= commit_data;
    end

    assign bus.readData = rdata;
    assign bus.ready    = (state == DONE);
    assign bus.busy     = (state != IDLE);
    assign bus.error    = err;
endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed table, corner sequences, random vs model.
module tb_data_memory_responder;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 32;

    logic clock = 1'b0;
    logic resetN;
    int   checks = 0;
    int   failures = 0;

    data_memory_responder_if bus();

    data_memory_responder #(.WAIT_CYCLES(WAIT_CYCLES), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    logic [63:0] model_mem [DEPTH_WORDS];
    logic [63:0] last_rd;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit is_misal(input logic [63:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
        return a[2:0] != 3'b000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a >> 3) % 64'(DEPTH_WORDS));
    endfunction

    // One full transaction; checks latency, single ready pulse, data and error.
    task automatic op(input bit wr, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] got);
        int  lat;
        bit  seen;
        bit  mis;
        bus.memoryWrite = wr;
        bus.memoryRead  = !wr;
        bus.address     = a;
        bus.writeData   = d;
        step();
        chk("accept_busy", 64'(bus.busy), 64'd1);
        bus.memoryWrite = 1'b0;
        bus.memoryRead  = 1'b0;
        bus.address     = {$urandom, $urandom};
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (bus.ready) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("latency", 64'(lat), 64'(WAIT_CYCLES + 1));
        mis = is_misal(a);
        if (!wr && !mis)
            last_rd = model_mem[idx_of(a)];
        if (wr && !mis)
            model_mem[idx_of(a)] = d;
        chk("read_data", bus.readData, last_rd);
        chk("error_with_ready", 64'(bus.error), 64'(mis));
        got = bus.readData;
        step();
        chk("ready_one_cycle", 64'(bus.ready), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("error_after_done", 64'(bus.error), 64'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [63:0] got;
        int          nready;

        resetN          = 1'b0;
        bus.memoryRead  = 1'b0;
        bus.memoryWrite = 1'b0;
        bus.address     = 64'd0;
        bus.writeData   = 64'd0;
        last_rd         = 64'd0;
        foreach (model_mem[i]) model_mem[i] = 64'd0;
        #2;
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_error", 64'(bus.error), 64'd0);
        chk("reset_readData", bus.readData, 64'd0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        // Preload every word so later reads have a known reference.
        for (int i = 0; i < DEPTH_WORDS; i++)
            op(1'b1, 64'(i * 8), {$urandom, $urandom}, got);

        vecs.push_back('{1'b1, 64'h10,  64'hDEADBEEF_00000001, 64'h0});
        vecs.push_back('{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_00000001});
        vecs.push_back('{1'b1, 64'h100, 64'h5, 64'h0});
        vecs.push_back('{1'b0, 64'h00,  64'h0, 64'h5});
        vecs.push_back('{1'b1, 64'h08,  64'h1111, 64'h0});
        vecs.push_back('{1'b1, 64'h18,  64'h2222, 64'h0});
        vecs.push_back('{1'b1, 64'h20,  64'h3333, 64'h0});
        vecs.push_back('{1'b0, 64'h08,  64'h0, 64'h1111});
        vecs.push_back('{1'b1, 64'hF8,  64'hAAAA_5555_0000_FFFF, 64'h0});
        vecs.push_back('{1'b0, 64'h1F8, 64'h0, 64'hAAAA_5555_0000_FFFF});
        vecs.push_back('{1'b0, 64'hFFFF_0000_0000_0018, 64'h0, 64'h2222});
        foreach (vecs[i]) begin
            op(vecs[i].wr, vecs[i].addr, vecs[i].data, got);
            if (!vecs[i].wr) chk($sformatf("vec%0d_data", i), got, vecs[i].exp);
        end

        // Both request lines high: ignored.
        bus.memoryRead  = 1'b1;
        bus.memoryWrite = 1'b1;
        bus.address     = 64'h10;
        bus.writeData   = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("both_busy", 64'(bus.busy), 64'd0);
            chk("both_ready", 64'(bus.ready), 64'd0);
        end
        bus.memoryRead  = 1'b0;
        bus.memoryWrite = 1'b0;
        op(1'b0, 64'h10, 64'h0, got);
        chk("both_mem_unchanged", got, 64'hDEADBEEF_00000001);

        // Second request while busy is dropped.
        bus.memoryRead = 1'b1;
        bus.address    = 64'h08;
        step();
        bus.address = 64'h18;
        step();
        step();
        bus.memoryRead = 1'b0;
        nready = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.ready) nready++;
            if (bus.ready) chk("busy_drop_data", bus.readData, 64'h1111);
        end
        chk("busy_drop_ready_count", 64'(nready), 64'd1);
        last_rd = 64'h1111;

        // Reset during WAIT abandons the store.
        bus.memoryWrite = 1'b1;
        bus.address     = 64'h20;
        bus.writeData   = 64'h9999_9999_9999_9999;
        step();
        bus.memoryWrite = 1'b0;
        step();
        #2 resetN = 1'b0;
        #1;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_ready", 64'(bus.ready), 64'd0);
        chk("midreset_readData", bus.readData, 64'd0);
        chk("midreset_error", 64'(bus.error), 64'd0);
        last_rd = 64'd0;
        @(negedge clock);
        resetN = 1'b1;
        op(1'b0, 64'h20, 64'h0, got);
        chk("midreset_old_contents", got, 64'h3333);

        // Misaligned store then read back word 1 (suppressed only with the check enabled).
        op(1'b1, 64'h0C, 64'h7, got);
        op(1'b0, 64'h08, 64'h0, got);

        for (int n = 0; n < 150; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[2:0] = 3'b000;
            op(1'($urandom_range(1)), a, {$urandom, $urandom}, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
